dmem_arbiter: RTL

Arbiter that shares the single-port synchronous data memory of the Proyecto2 processor between two requesters: the CPU load/store unit (read/write) and the VGA pixel fetcher (read-only). The VGA fetcher has priority during active video. The CPU has priority during blanking. A starvation counter guarantees the CPU forward progress. The block sits between the core's data-memory port, the VGA controller and the RAM macro, and is clocked by the 50 MHz system clock.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data memory
//
// Purpose:
//   Shares one single-port synchronous RAM between the CPU load/store unit
//   (read/write) and the VGA pixel fetcher (read-only). VGA wins during active
//   video, the CPU wins during blanking, and a starvation counter forces a CPU
//   grant after STARVE_MAX consecutive refused CPU-request cycles.
//
// Ports:
//   CLOCK_50, reset        - system clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  - CPU request, held until cpu_gnt
//   cpu_gnt                - combinational CPU accept
//   cpu_rvalid/cpu_rdata   - CPU read response, two edges after accept
//   vga_req/addr/blank     - VGA read request and blanking indication
//   vga_gnt                - combinational VGA accept
//   vga_rvalid/vga_rdata   - VGA read response, two edges after accept
//   mem_en/we/addr/wdata   - registered RAM strobes and operands
//   mem_rdata              - RAM read data, valid the cycle after mem_en
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_blank,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] MODE_VGA_PRIO  = 2'd0;
  localparam logic [1:0] MODE_CPU_PRIO  = 2'd1;
  localparam logic [1:0] MODE_FORCE_CPU = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VGA  = 2'd2;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       mode;
  logic             cpu_win;
  logic             vga_win;
  logic             issue_cpu;
  logic [1:0]       owner;

  // Grant mode is decoded from registered state and the blanking input;
  // a saturated starvation counter overrides everything else.
  always_comb begin
    mode = MODE_VGA_PRIO;
    if (starve_cnt == STARVE_LIM) begin
      mode = MODE_FORCE_CPU;
    end else if (vga_blank) begin
      mode = MODE_CPU_PRIO;
    end
  end

  // In FORCE_CPU with cpu_req low the slot is not wasted: VGA takes it.
  always_comb begin
    cpu_win = 1'b0;
    case (mode)
      MODE_FORCE_CPU: cpu_win = cpu_req;
      MODE_CPU_PRIO:  cpu_win = cpu_req;
      default:        cpu_win = cpu_req && !vga_req;
    endcase
    vga_win = vga_req && !cpu_win;
  end

  // Only the visible grants are masked by reset; the internal winners feed
  // the flops, which are held cleared by the asynchronous reset anyway.
  assign cpu_gnt = reset && cpu_win;
  assign vga_gnt = reset && vga_win;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!cpu_req || cpu_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Issue stage: address/data hold when idle so the RAM pins stay quiet.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      issue_cpu <= 1'b0;
    end else if (cpu_win) begin
      mem_en    <= 1'b1;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
      issue_cpu <= 1'b1;
    end else if (vga_win) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= vga_addr;
      issue_cpu <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Response stage: tags the RAM output cycle with its requester; writes
  // produce no response.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      owner <= OWN_NONE;
    end else if (mem_en && !mem_we) begin
      owner <= issue_cpu ? OWN_CPU : OWN_VGA;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign vga_rvalid = (owner == OWN_VGA);
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule
